// File: rtl/ldm_stm_pkg.sv
// Shared constants and types for the load/store-multiple sequencer.
package ldm_stm_pkg;

    localparam int P_BIT      = 24;
    localparam int U_BIT      = 23;
    localparam int W_BIT      = 21;
    localparam int L_BIT      = 20;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        XFER   = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Addressing-mode and direction bits captured from the instruction.
    typedef struct packed {
        logic p;
        logic u;
        logic w;
        logic l;
    } mode_t;

endpackage

// File: rtl/ldm_stm_sequencer_reg_list_scan.sv
// Combinational scan of a 16-bit register list: count, lowest set index, non-empty flag.
module reg_list_scan (
    input  logic [15:0] list,
    output logic [4:0]  popcount,
    output logic [3:0]  lowest_idx,
    output logic        any
);

    always_comb begin
        popcount   = '0;
        lowest_idx = '0;
        // Descending walk so the last hit left in lowest_idx is the lowest index.
        for (int i = 15; i >= 0; i--) begin
            if (list[i]) begin
                popcount   = popcount + 5'd1;
                lowest_idx = 4'(i);
            end
        end
        any = |list;
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM beat sequencer: walks the register list, issues one register/address per
// beat and produces the base writeback value on completion.
module ldm_stm_sequencer
    import ldm_stm_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = ldm_stm_pkg::WORD_BYTES
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [31:0]       IR,
    input  logic [ADDR_W-1:0] BASE,
    input  logic              MEM_READY,
    output logic              BUSY,
    output logic              XFER_VALID,
    output logic [3:0]        REG_NUM,
    output logic [ADDR_W-1:0] ADDR,
    output logic              XFER_LOAD,
    output logic              WB_EN,
    output logic [ADDR_W-1:0] WB_VALUE,
    output logic              DONE
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

    state_t            state, state_nxt;
    mode_t             mode_q;
    logic [15:0]       list_q;
    logic [ADDR_W-1:0] base_q, addr_q, wb_q;
    logic              nz_q;

    logic [4:0]        pop;
    logic [3:0]        low;
    logic              any;
    logic [ADDR_W-1:0] offset, start_addr, wb_next;
    logic              unused_ir;

    assign unused_ir = ^{IR[31:25], IR[22], IR[19:16]};

    // list_q holds the full list in CALC and the remaining list in XFER.
    reg_list_scan u_scan (
        .list       (list_q),
        .popcount   (pop),
        .lowest_idx (low),
        .any        (any)
    );

    assign offset  = ADDR_W'(pop) * STEP;
    assign wb_next = mode_q.u ? base_q + offset : base_q - offset;

    // Beats always ascend, so decrementing modes start at the lowest address of the block.
    always_comb begin
        case ({mode_q.p, mode_q.u})
            2'b01:   start_addr = base_q;
            2'b11:   start_addr = base_q + STEP;
            2'b00:   start_addr = base_q - offset + STEP;
            default: start_addr = base_q - offset;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = CALC;
            CALC:    state_nxt = any ? XFER : FINISH;
            XFER:    if (MEM_READY && pop == 5'd1) state_nxt = FINISH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            list_q <= '0;
            mode_q <= '0;
            base_q <= '0;
            addr_q <= '0;
            wb_q   <= '0;
            nz_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    list_q <= IR[15:0];
                    mode_q <= {IR[P_BIT], IR[U_BIT], IR[W_BIT], IR[L_BIT]};
                    base_q <= BASE;
                end
                CALC: begin
                    addr_q <= start_addr;
                    wb_q   <= wb_next;
                    nz_q   <= any;
                end
                XFER: if (MEM_READY) begin
                    list_q <= list_q & ~(16'd1 << low);
                    addr_q <= addr_q + STEP;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        BUSY       = (state != IDLE);
        XFER_VALID = 1'b0;
        REG_NUM    = '0;
        ADDR       = '0;
        XFER_LOAD  = 1'b0;
        WB_EN      = 1'b0;
        WB_VALUE   = '0;
        DONE       = 1'b0;
        case (state)
            XFER: begin
                XFER_VALID = 1'b1;
                REG_NUM    = low;
                ADDR       = addr_q;
                XFER_LOAD  = mode_q.l;
            end
            FINISH: begin
                DONE     = 1'b1;
                WB_EN    = mode_q.w & nz_q;
                WB_VALUE = WB_EN ? wb_q : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: stimulus queues expected beats/completions,
// a negedge monitor compares them against the DUT.
module tb_ldm_stm_sequencer;

    logic        CLK = 1'b0;
    logic        RESET, START, MEM_READY;
    logic [31:0] IR, BASE;
    logic        BUSY, XFER_VALID, XFER_LOAD, WB_EN, DONE;
    logic [3:0]  REG_NUM;
    logic [31:0] ADDR, WB_VALUE;

    ldm_stm_sequencer #(.ADDR_W(32), .WORD_BYTES(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .IR         (IR),
        .BASE       (BASE),
        .MEM_READY  (MEM_READY),
        .BUSY       (BUSY),
        .XFER_VALID (XFER_VALID),
        .REG_NUM    (REG_NUM),
        .ADDR       (ADDR),
        .XFER_LOAD  (XFER_LOAD),
        .WB_EN      (WB_EN),
        .WB_VALUE   (WB_VALUE),
        .DONE       (DONE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  r;
        logic [31:0] a;
        logic        l;
    } beat_t;

    typedef struct {
        logic        wb;
        logic [31:0] v;
        int          c;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(negedge CLK) begin : monitor
        done_t d;
        if (XFER_VALID) begin
            if (beat_q.size() == 0) fail_now("unexpected beat");
            else begin
                chk("beat reg/addr/load", 64'({REG_NUM, ADDR, XFER_LOAD}),
                    64'({beat_q[0].r, beat_q[0].a, beat_q[0].l}));
                if (MEM_READY) void'(beat_q.pop_front());
            end
        end
        if (DONE) begin
            if (done_q.size() == 0) fail_now("unexpected done");
            else begin
                d = done_q.pop_front();
                chk("done cycle", 64'(cyc), 64'(d.c));
                chk("wb_en", 64'(WB_EN), 64'(d.wb));
                if (d.wb) chk("wb_value", 64'(WB_VALUE), 64'(d.v));
                chk("busy at done", 64'(BUSY), 64'(1));
            end
        end else if (WB_EN) fail_now("wb_en without done");
    end

    function automatic logic [31:0] mk_ir(input logic p, u, w, l, input logic [15:0] list);
        return {4'hE, 3'b100, p, u, 1'b0, w, l, 4'd13, list};
    endfunction

    task automatic chk_idle_outputs(input string name);
        chk(name, 64'({BUSY, XFER_VALID, REG_NUM, XFER_LOAD, WB_EN, DONE}), 64'(0));
        chk({name, " addr/wb"}, {ADDR, WB_VALUE}, 64'(0));
    endtask

    task automatic push_beats(input logic [15:0] list, input logic [31:0] first, input logic l,
                              output int n);
        logic [31:0] a;
        a = first;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                beat_q.push_back('{4'(i), a, l});
                a = a + 32'd4;
                n++;
            end
        end
    endtask

    task automatic run_op(input logic p, u, w, l, input logic [15:0] list,
                          input logic [31:0] base, first, wbv, input logic exp_wb,
                          input int waits, input bit poke);
        int n;
        push_beats(list, first, l, n);
        @(posedge CLK); #1;
        done_q.push_back('{exp_wb, wbv, cyc + n + 2 + waits});
        MEM_READY = (waits == 0);
        IR        = mk_ir(p, u, w, l, list);
        BASE      = base;
        START     = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        IR    = '0;
        BASE  = '0;
        if (waits > 0) begin
            repeat (1 + waits) @(posedge CLK);
            #1 MEM_READY = 1'b1;
        end
        if (poke) begin
            @(posedge CLK); #1;
            START = 1'b1;
            IR    = mk_ir(1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF);
            BASE  = 32'hDEAD_0000;
            @(posedge CLK); #1;
            START = 1'b0;
            IR    = '0;
            BASE  = '0;
        end
        for (int t = 0; t < 64 && done_q.size() != 0; t++) @(posedge CLK);
        if (done_q.size() != 0) begin
            fail_now("timeout waiting for done");
            done_q.delete();
            beat_q.delete();
        end
        #1;
    endtask

    initial begin
        int n;
        RESET     = 1'b1;
        START     = 1'b0;
        MEM_READY = 1'b0;
        IR        = '0;
        BASE      = '0;
        repeat (2) @(posedge CLK);
        #1 chk_idle_outputs("reset outputs");
        RESET = 1'b0;

        // IA load, W=1
        run_op(1'b0, 1'b1, 1'b1, 1'b1, 16'h000F, 32'h100, 32'h100, 32'h110, 1'b1, 0, 1'b0);
        // DB store, W=1
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h8001, 32'h200, 32'h1F8, 32'h1F8, 1'b1, 0, 1'b0);
        // IB with three wait states on the single beat, W=0
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 32'h40, 32'h44, 32'h0, 1'b0, 3, 1'b0);
        // Empty list with W=1: no beats, no writeback
        run_op(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 32'h80, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        // DA full list wrapping below zero
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 32'h20, 32'hFFFF_FFE4, 32'hFFFF_FFE0, 1'b1, 0, 1'b0);
        // Rn (R13) in the list with W=1 still writes back
        run_op(1'b1, 1'b1, 1'b1, 1'b1, 16'h2004, 32'h500, 32'h504, 32'h508, 1'b1, 0, 1'b0);

        // Reset during the third beat abandons the sequence
        push_beats(16'h00FF, 32'h300, 1'b0, n);
        @(posedge CLK); #1;
        MEM_READY = 1'b1;
        IR        = mk_ir(1'b0, 1'b1, 1'b1, 1'b0, 16'h00FF);
        BASE      = 32'h300;
        START     = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b1;
        #1 chk_idle_outputs("async reset mid-transfer");
        chk("beats before reset", 64'(beat_q.size()), 64'(n - 2));
        beat_q.delete();
        @(posedge CLK); #1 RESET = 1'b0;
        repeat (6) @(posedge CLK);
        #1;

        // Sequence after reset, with a stray START during XFER
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h0F00, 32'h1000, 32'h1000, 32'h0, 1'b0, 0, 1'b1);

        repeat (6) @(posedge CLK);
        #1;
        chk("beat queue drained", 64'(beat_q.size()), 64'(0));
        chk("done queue drained", 64'(done_q.size()), 64'(0));
        chk_idle_outputs("final idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
